// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/RETIRE sequencer for the 8-bit core's datapath.
// All outputs are flops loaded from the next-state decode, so no input reaches an output combinationally.
module instr_sequencer #(
   parameter int MEM_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   input  logic       halt_req,
   input  logic [2:0] opcode,
   input  logic       mem_ready,
   output logic       ir_load,
   output logic       alu_en,
   output logic       mem_rd_en,
   output logic       mem_wr_en,
   output logic       reg_write_en,
   output logic       pc_en,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_RETIRE = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [2:0] OP_LW     = 3'b110;
   localparam logic [2:0] OP_SW     = 3'b111;
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic       step_mode_q, step_mode_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ir_load_q, ir_load_d;
   logic       alu_en_q, alu_en_d;
   logic       mem_rd_en_q, mem_rd_en_d;
   logic       mem_wr_en_q, mem_wr_en_d;
   logic       reg_write_en_q, reg_write_en_d;
   logic       pc_en_q, pc_en_d;
   logic       busy_q, busy_d;
   logic       fault_q, fault_d;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      step_mode_d = step_mode_q;
      wait_d      = wait_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b0;
            end else if (step) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b1;
            end
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            op_d    = opcode;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            wait_d  = 8'd0;
            state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
         end
         S_MEM: begin
            // A ready in the last allowed cycle still completes the access.
            if (mem_ready) begin
               state_d = (op_q == OP_SW) ? S_RETIRE : S_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB:     state_d = S_RETIRE;
         S_RETIRE: begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (run && !halt_req && !step_mode_q) ? S_FETCH : S_IDLE;
         end
         default:  state_d = S_FAULT;
      endcase

      ir_load_d      = (state_d == S_FETCH);
      alu_en_d       = (state_d == S_EXEC);
      mem_rd_en_d    = (state_d == S_MEM) && (op_d == OP_LW);
      mem_wr_en_d    = (state_d == S_MEM) && (op_d == OP_SW);
      reg_write_en_d = (state_d == S_WB);
      pc_en_d        = (state_d == S_RETIRE);
      busy_d         = (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_d        = (state_d == S_FAULT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         op_q           <= 3'b000;
         step_mode_q    <= 1'b0;
         wait_q         <= 8'd0;
         cnt_q          <= 8'd0;
         ir_load_q      <= 1'b0;
         alu_en_q       <= 1'b0;
         mem_rd_en_q    <= 1'b0;
         mem_wr_en_q    <= 1'b0;
         reg_write_en_q <= 1'b0;
         pc_en_q        <= 1'b0;
         busy_q         <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         step_mode_q    <= step_mode_d;
         wait_q         <= wait_d;
         cnt_q          <= cnt_d;
         ir_load_q      <= ir_load_d;
         alu_en_q       <= alu_en_d;
         mem_rd_en_q    <= mem_rd_en_d;
         mem_wr_en_q    <= mem_wr_en_d;
         reg_write_en_q <= reg_write_en_d;
         pc_en_q        <= pc_en_d;
         busy_q         <= busy_d;
         fault_q        <= fault_d;
      end
   end

   assign state        = state_q;
   assign instr_count  = cnt_q;
   assign ir_load      = ir_load_q;
   assign alu_en       = alu_en_q;
   assign mem_rd_en    = mem_rd_en_q;
   assign mem_wr_en    = mem_wr_en_q;
   assign reg_write_en = reg_write_en_q;
   assign pc_en        = pc_en_q;
   assign busy         = busy_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, directed corner sequences and random traffic
// checked every cycle against a phase-queue model of the instruction flow.
module tb_instr_sequencer;

   localparam int T = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0, step = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       ir_load, alu_en, mem_rd_en, mem_wr_en, reg_write_en, pc_en, busy, fault;
   logic [2:0] state;
   logic [7:0] instr_count;

   int checks = 0;
   int errors = 0;

   instr_sequencer #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
      .opcode(opcode), .mem_ready(mem_ready), .ir_load(ir_load), .alu_en(alu_en),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .reg_write_en(reg_write_en),
      .pc_en(pc_en), .busy(busy), .fault(fault), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Model: queue of phases still to run for the current instruction; empty means idle.
   int         ph[$];
   bit         m_fault, m_step;
   logic [2:0] m_op;
   int         m_wait, m_cnt;

   task automatic model_reset();
      ph.delete();
      m_fault = 0; m_step = 0; m_op = 3'd0; m_wait = 0; m_cnt = 0;
   endtask

   task automatic model_advance(input bit r, input bit s, input bit h, input logic [2:0] op, input bit rdy);
      if (m_fault) return;
      if (ph.size() == 0) begin
         if (r || s) begin
            ph.push_back(1); ph.push_back(2);
            m_step = !r;
         end
         return;
      end
      case (ph[0])
         2: begin
            m_op = op; m_wait = 0;
            void'(ph.pop_front());
            ph.push_back(3);
            if (op == 3'd6 || op == 3'd7) ph.push_back(4);
            if (op != 3'd7) ph.push_back(5);
            ph.push_back(6);
         end
         4: begin
            if (rdy) void'(ph.pop_front());
            else begin
               m_wait++;
               if (m_wait == T) begin m_fault = 1; ph.delete(); end
            end
         end
         6: begin
            m_cnt = (m_cnt + 1) % 256;
            void'(ph.pop_front());
            if (r && !h && !m_step) begin ph.push_back(1); ph.push_back(2); end
         end
         default: void'(ph.pop_front());
      endcase
   endtask

   function automatic logic [18:0] model_out();
      int cur;
      cur = m_fault ? 7 : (ph.size() == 0 ? 0 : ph[0]);
      return {3'(cur), 8'(m_cnt), cur == 1, cur == 3, cur == 4 && m_op == 3'd6,
              cur == 4 && m_op == 3'd7, cur == 5, cur == 6, cur != 0 && cur != 7, cur == 7};
   endfunction

   function automatic logic [18:0] dut_out();
      return {state, instr_count, ir_load, alu_en, mem_rd_en, mem_wr_en, reg_write_en,
              pc_en, busy, fault};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit h, input logic [2:0] op, input bit rdy);
      run = r; step = s; halt_req = h; opcode = op; mem_ready = rdy;
      model_advance(r, s, h, op, rdy);
      @(posedge clk); #1;
      check("model", 32'(dut_out()), 32'(model_out()));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check("reset", 32'(dut_out()), 32'(model_out()));
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic       r, s, h;
      logic [2:0] op;
      logic       rdy;
      logic [2:0] st;
      logic [5:0] en;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // Stepped lw with 3 waits (stray step/opcode changes ignored), then a halted sw.
      tbl[0]  = '{0, 1, 0, 3'd6, 0, 3'd1, 6'h20, 8'd0};
      tbl[1]  = '{0, 0, 0, 3'd6, 0, 3'd2, 6'h00, 8'd0};
      tbl[2]  = '{0, 0, 0, 3'd6, 0, 3'd3, 6'h10, 8'd0};
      tbl[3]  = '{0, 1, 0, 3'd0, 0, 3'd4, 6'h08, 8'd0};
      tbl[4]  = '{0, 0, 0, 3'd0, 0, 3'd4, 6'h08, 8'd0};
      tbl[5]  = '{0, 0, 0, 3'd0, 0, 3'd4, 6'h08, 8'd0};
      tbl[6]  = '{0, 0, 0, 3'd0, 0, 3'd4, 6'h08, 8'd0};
      tbl[7]  = '{0, 0, 0, 3'd0, 1, 3'd5, 6'h02, 8'd0};
      tbl[8]  = '{0, 1, 0, 3'd0, 0, 3'd6, 6'h01, 8'd0};
      tbl[9]  = '{0, 0, 0, 3'd0, 0, 3'd0, 6'h00, 8'd1};
      tbl[10] = '{1, 0, 0, 3'd0, 0, 3'd1, 6'h20, 8'd1};
      tbl[11] = '{1, 0, 0, 3'd0, 0, 3'd2, 6'h00, 8'd1};
      tbl[12] = '{1, 0, 0, 3'd7, 0, 3'd3, 6'h10, 8'd1};
      tbl[13] = '{1, 0, 1, 3'd0, 1, 3'd4, 6'h04, 8'd1};
      tbl[14] = '{1, 0, 1, 3'd0, 1, 3'd6, 6'h01, 8'd1};
      tbl[15] = '{1, 0, 1, 3'd0, 0, 3'd0, 6'h00, 8'd2};
      tbl[16] = '{0, 0, 0, 3'd0, 0, 3'd0, 6'h00, 8'd2};

      #2;
      do_reset();
      check("reset_state", 32'({state, busy, fault, instr_count}), 32'd0);

      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].op, tbl[i].rdy);
         check($sformatf("vec%0d", i),
               32'({state, ir_load, alu_en, mem_rd_en, mem_wr_en, reg_write_en, pc_en, instr_count}),
               32'({tbl[i].st, tbl[i].en, tbl[i].cnt}));
      end

      // Continuous ALU run: four retires within 21 edges, one every 5 cycles.
      do_reset();
      for (int i = 0; i < 21; i++) cyc(1, 0, 0, 3'd0, 0);
      check("alu_run_count", 32'(instr_count), 32'd4);

      // Ready arriving in the last allowed MEM cycle completes instead of faulting.
      do_reset();
      cyc(0, 1, 0, 3'd6, 0); cyc(0, 0, 0, 3'd6, 0); cyc(0, 0, 0, 3'd6, 0); cyc(0, 0, 0, 3'd6, 0);
      for (int i = 0; i < T - 1; i++) cyc(0, 0, 0, 3'd6, 0);
      cyc(0, 0, 0, 3'd6, 1);
      check("ready_wins", 32'({state, fault}), 32'({3'd5, 1'b0}));

      // Timeout: 8 not-ready MEM cycles -> FAULT, sticky until reset.
      do_reset();
      for (int i = 0; i < 11; i++) cyc(0, i == 0, 0, 3'd6, 0);
      check("pre_fault", 32'(state), 32'd4);
      cyc(0, 0, 0, 3'd6, 0);
      check("fault_entry", 32'({state, fault, busy}), 32'({3'd7, 1'b1, 1'b0}));
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, 3'd0, 1);
      check("fault_sticky", 32'(state), 32'd7);
      do_reset();
      check("fault_cleared", 32'({state, fault, instr_count}), 32'd0);

      // Async reset in WB aborts without retiring.
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 3'd0, 0);
      check("in_wb", 32'(state), 32'd5);
      do_reset();
      check("wb_reset", 32'({state, pc_en, instr_count}), 32'd0);

      // Counter wrap on the 256th retire.
      for (int i = 0; i < 1280; i++) cyc(1, 0, 0, 3'd0, 0);
      check("count_255", 32'(instr_count), 32'd255);
      cyc(1, 0, 0, 3'd0, 0);
      check("count_wrap", 32'(instr_count), 32'd0);

      // Random traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
